layered_cnu_sched_ctrl: RTL and testbench
=========================================

LAYERED_CNU_SCHED_CTRL -- requirements
Module: layered_cnu_sched_ctrl

Interface
REQ-001 SHALL have parameter LAYER_NUM, default 3: layers per iteration, at least 2.
REQ-002 SHALL have parameter MAX_ITER, default 10: iterations before giving up, at least 1.
REQ-003 SHALL have parameters MEM_RD_LEVEL, CNU_PIPELINE_LEVEL, PERMUTATION_LEVEL, PAGE_ALIGN_LEVEL and VNU_BUBBLE_LEVEL, defaults 2, 4, 2, 1 and 2: the stage dwell in cycles, each at least 1.
REQ-004 SHALL have port read_clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port frame_start, input, 1 bit: one-cycle pulse that starts decoding a frame.
REQ-007 SHALL have inputs vnu_update_pend (VNU IB-RAM update in progress), layer_finish (current layer retired) and syndrome_ok (all checks satisfied), each 1 bit.
REQ-008 SHALL have outputs v2c_mem_fetch, cnu_rd, c2v_bs_en, c2v_pa_en and c2v_mem_we, each 1 bit: datapath strobes.
REQ-009 SHALL have outputs layer_idx ($clog2(LAYER_NUM) bits), iter_idx ($clog2(MAX_ITER+1) bits) and last_layer (1 bit).
REQ-010 SHALL have outputs busy, frame_done and decode_fail (1 bit each) and state (4 bits).

Function
REQ-011 SHALL implement the states IDLE=0, VNU_PEND=1, VNU_BUBBLE=2, MEM_FETCH=3, CNU_PIPE=4, BS_WB=5, PAGE_ALIGN=6, MEM_WB=7, LAYER_WAIT=8 and DONE=9; any other encoding SHALL go to IDLE on the next cycle.
REQ-012 SHALL, in IDLE, go to VNU_PEND on frame_start and clear layer_idx and iter_idx to 0; frame_start outside IDLE SHALL be ignored.
REQ-013 SHALL hold VNU_PEND while vnu_update_pend=1 and go to VNU_BUBBLE once it is 0.
REQ-014 SHALL dwell exactly VNU_BUBBLE_LEVEL cycles in VNU_BUBBLE, then go to MEM_FETCH.
REQ-015 SHALL dwell exactly MEM_RD_LEVEL cycles in MEM_FETCH, with v2c_mem_fetch=1 on the first of those cycles only.
REQ-016 SHALL dwell exactly CNU_PIPELINE_LEVEL cycles in CNU_PIPE, with cnu_rd=1 on every one of those cycles.
REQ-017 SHALL dwell exactly PERMUTATION_LEVEL cycles in BS_WB, with c2v_bs_en=1 on the first of those cycles only.
REQ-018 SHALL dwell exactly PAGE_ALIGN_LEVEL cycles in PAGE_ALIGN, with c2v_pa_en=1 throughout.
REQ-019 SHALL spend exactly 1 cycle in MEM_WB, with c2v_mem_we=1, then go to LAYER_WAIT.
REQ-020 SHALL use one shared dwell counter, reloaded on every state entry, sized for the largest LEVEL parameter.
REQ-021 SHALL, in LAYER_WAIT with layer_finish=1 and last_layer=0, increment layer_idx and go to VNU_PEND if vnu_update_pend=1, else to MEM_FETCH.
REQ-022 SHALL, in LAYER_WAIT with layer_finish=1 and last_layer=1, wrap layer_idx to 0 and increment iter_idx.
REQ-023 SHALL then go to DONE with decode_fail=1 if the incremented iter_idx equals MAX_ITER, otherwise continue as in REQ-021.
REQ-024 SHALL ignore layer_finish in every state other than LAYER_WAIT.
REQ-025 SHALL drive last_layer=1 exactly when layer_idx equals LAYER_NUM-1.
REQ-026 SHALL spend 1 cycle in DONE with frame_done=1, then go to IDLE; decode_fail SHALL hold until the next frame_start.
REQ-027 SHALL drive busy=1 in every state except IDLE.
REQ-028 SHALL derive all strobes combinationally from state and the dwell counter only.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, force state=IDLE, layer_idx=0, iter_idx=0, decode_fail=0 and the dwell counter to 0 at any point in operation.
REQ-030 SHALL hold all strobes, busy and frame_done at 0 during reset and drop any frame in flight.

Configuration
REQ-031 SHALL, with macro EARLY_TERM_EN defined, go from LAYER_WAIT to DONE with decode_fail=0 when layer_finish=1, last_layer=1 and syndrome_ok=1, and this SHALL take priority over the MAX_ITER check.
REQ-032 SHALL, with EARLY_TERM_EN undefined, ignore syndrome_ok and always run MAX_ITER iterations.

Verification
REQ-033 SHALL test default parameters with vnu_update_pend=0 and layer_finish pulsed 2 cycles after each c2v_mem_we: exactly 30 c2v_mem_we pulses, then frame_done with decode_fail=1 and iter_idx=10.
REQ-034 SHALL test EARLY_TERM_EN with syndrome_ok=1 at the third layer_finish: frame_done follows 1 cycle later with decode_fail=0 and iter_idx=1.
REQ-035 SHALL test per-layer timing with CNU_PIPELINE_LEVEL=6: v2c_mem_fetch, then cnu_rd high for exactly 6 cycles starting 2 cycles later, then c2v_bs_en 1 pulse, c2v_pa_en 1 cycle and c2v_mem_we 1 cycle, back to back.
REQ-036 SHALL test vnu_update_pend held at 1 for 5 cycles: the block waits in VNU_PEND for those 5 cycles with no strobes, then enters VNU_BUBBLE for 2 cycles.
REQ-037 SHALL test rst=1 asserted in CNU_PIPE: the next cycle shows state=0 and all outputs 0, and a new frame_start restarts cleanly.
REQ-038 SHALL test frame_start pulsed during BS_WB and layer_finish pulsed during MEM_FETCH: both are ignored with no change to layer_idx or iter_idx.

Source files
------------

// File: rtl/layered_cnu_sched_ctrl.sv
// Layer/iteration scheduler for a layered LDPC check-node datapath.
// Define EARLY_TERM_EN to stop on syndrome_ok at the end of an iteration.
module layered_cnu_sched_ctrl #(
   parameter int LAYER_NUM          = 3,
   parameter int MAX_ITER           = 10,
   parameter int MEM_RD_LEVEL       = 2,
   parameter int CNU_PIPELINE_LEVEL = 4,
   parameter int PERMUTATION_LEVEL  = 2,
   parameter int PAGE_ALIGN_LEVEL   = 1,
   parameter int VNU_BUBBLE_LEVEL   = 2
) (
   input  logic                            read_clk,
   input  logic                            rst,
   input  logic                            frame_start,
   input  logic                            vnu_update_pend,
   input  logic                            layer_finish,
   input  logic                            syndrome_ok,
   output logic                            v2c_mem_fetch,
   output logic                            cnu_rd,
   output logic                            c2v_bs_en,
   output logic                            c2v_pa_en,
   output logic                            c2v_mem_we,
   output logic [$clog2(LAYER_NUM)-1:0]    layer_idx,
   output logic [$clog2(MAX_ITER+1)-1:0]   iter_idx,
   output logic                            last_layer,
   output logic                            busy,
   output logic                            frame_done,
   output logic                            decode_fail,
   output logic [3:0]                      state
);

   localparam int LW  = $clog2(LAYER_NUM);
   localparam int IW  = $clog2(MAX_ITER+1);
   localparam int MX1 = (MEM_RD_LEVEL > CNU_PIPELINE_LEVEL) ?
                        MEM_RD_LEVEL : CNU_PIPELINE_LEVEL;
   localparam int MX2 = (PERMUTATION_LEVEL > PAGE_ALIGN_LEVEL) ?
                        PERMUTATION_LEVEL : PAGE_ALIGN_LEVEL;
   localparam int MX3 = (MX1 > MX2) ? MX1 : MX2;
   localparam int MXL = (MX3 > VNU_BUBBLE_LEVEL) ? MX3 : VNU_BUBBLE_LEVEL;
   localparam int CW  = (MXL > 1) ? $clog2(MXL) : 1;

   localparam logic [CW-1:0] MR_TOP = CW'(MEM_RD_LEVEL - 1);
   localparam logic [CW-1:0] CP_TOP = CW'(CNU_PIPELINE_LEVEL - 1);
   localparam logic [CW-1:0] PM_TOP = CW'(PERMUTATION_LEVEL - 1);
   localparam logic [CW-1:0] PA_TOP = CW'(PAGE_ALIGN_LEVEL - 1);
   localparam logic [CW-1:0] VB_TOP = CW'(VNU_BUBBLE_LEVEL - 1);
   localparam logic [LW-1:0] LAST_L = LW'(LAYER_NUM - 1);
   localparam logic [IW-1:0] ITER_N = IW'(MAX_ITER);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_VNU_PEND   = 4'd1;
   localparam logic [3:0] S_VNU_BUBBLE = 4'd2;
   localparam logic [3:0] S_MEM_FETCH  = 4'd3;
   localparam logic [3:0] S_CNU_PIPE   = 4'd4;
   localparam logic [3:0] S_BS_WB      = 4'd5;
   localparam logic [3:0] S_PAGE_ALIGN = 4'd6;
   localparam logic [3:0] S_MEM_WB     = 4'd7;
   localparam logic [3:0] S_LAYER_WAIT = 4'd8;
   localparam logic [3:0] S_DONE       = 4'd9;

   logic [3:0]    state_q, state_d, resume;
   logic [CW-1:0] cnt_q, cnt_d, cnt_ld;
   logic [LW-1:0] layer_q, layer_d;
   logic [IW-1:0] iter_q, iter_d;
   logic          fail_q, fail_d;
   logic          cnt_done, last_w, term_ok;

   assign cnt_done = (cnt_q == '0);
   assign last_w   = (layer_q == LAST_L);

`ifndef EARLY_TERM_EN
   logic unused_syndrome;
   assign unused_syndrome = syndrome_ok;
`endif

   // Next state, layer/iteration bookkeeping and failure flag.
   always_comb begin
      state_d = state_q;
      layer_d = layer_q;
      iter_d  = iter_q;
      fail_d  = fail_q;
      resume  = vnu_update_pend ? S_VNU_PEND : S_MEM_FETCH;
      term_ok = 1'b0;
`ifdef EARLY_TERM_EN
      term_ok = syndrome_ok;
`endif
      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d = S_VNU_PEND;
               layer_d = '0;
               iter_d  = '0;
               fail_d  = 1'b0;
            end
         end
         S_VNU_PEND:   if (!vnu_update_pend) state_d = S_VNU_BUBBLE;
         S_VNU_BUBBLE: if (cnt_done) state_d = S_MEM_FETCH;
         S_MEM_FETCH:  if (cnt_done) state_d = S_CNU_PIPE;
         S_CNU_PIPE:   if (cnt_done) state_d = S_BS_WB;
         S_BS_WB:      if (cnt_done) state_d = S_PAGE_ALIGN;
         S_PAGE_ALIGN: if (cnt_done) state_d = S_MEM_WB;
         S_MEM_WB:     state_d = S_LAYER_WAIT;
         S_LAYER_WAIT: begin
            if (layer_finish) begin
               if (!last_w) begin
                  layer_d = layer_q + LW'(1);
                  state_d = resume;
               end else begin
                  layer_d = '0;
                  iter_d  = iter_q + IW'(1);
                  if (term_ok) begin
                     state_d = S_DONE;
                  end else if (iter_d == ITER_N) begin
                     state_d = S_DONE;
                     fail_d  = 1'b1;
                  end else begin
                     state_d = resume;
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Shared dwell counter: reload on state entry, count down to zero.
   always_comb begin
      cnt_ld = '0;
      case (state_d)
         S_VNU_BUBBLE: cnt_ld = VB_TOP;
         S_MEM_FETCH:  cnt_ld = MR_TOP;
         S_CNU_PIPE:   cnt_ld = CP_TOP;
         S_BS_WB:      cnt_ld = PM_TOP;
         S_PAGE_ALIGN: cnt_ld = PA_TOP;
         default:      cnt_ld = '0;
      endcase
      if (state_d != state_q) cnt_d = cnt_ld;
      else if (cnt_done)      cnt_d = '0;
      else                    cnt_d = cnt_q - CW'(1);
   end

   // State registers with synchronous reset.
   always_ff @(posedge read_clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         layer_q <= '0;
         iter_q  <= '0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         layer_q <= layer_d;
         iter_q  <= iter_d;
         fail_q  <= fail_d;
      end
   end

   assign v2c_mem_fetch = (state_q == S_MEM_FETCH) && (cnt_q == MR_TOP);
   assign cnu_rd        = (state_q == S_CNU_PIPE);
   assign c2v_bs_en     = (state_q == S_BS_WB) && (cnt_q == PM_TOP);
   assign c2v_pa_en     = (state_q == S_PAGE_ALIGN);
   assign c2v_mem_we    = (state_q == S_MEM_WB);
   assign layer_idx     = layer_q;
   assign iter_idx      = iter_q;
   assign last_layer    = last_w;
   assign busy          = (state_q != S_IDLE);
   assign frame_done    = (state_q == S_DONE);
   assign decode_fail   = fail_q;
   assign state         = state_q;

endmodule

// File: tb/tb_layered_cnu_sched_ctrl.sv
// Bench for layered_cnu_sched_ctrl: directed steps plus a randomized
// full-frame run checked against a timing/iteration model.
module tb_layered_cnu_sched_ctrl;

   localparam int L  = 3;
   localparam int MI = 10;
   localparam int M  = 2;
   localparam int C  = 4;
   localparam int C6 = 6;
   localparam int P  = 2;
   localparam int A  = 1;
   localparam int B  = 2;

   logic clk, rst, frame_start, pend, lf, synd;

   logic       fetch, cnu, bs, pa, we, last, busy, fdone, dfail;
   logic [1:0] layer;
   logic [3:0] iter, st;

   logic       fetch6, cnu6, bs6, pa6, we6, last6, busy6, fdone6, dfail6;
   logic [1:0] layer6;
   logic [3:0] iter6, st6;

   int tests = 0;
   int fails = 0;

   layered_cnu_sched_ctrl dut (
      .read_clk(clk), .rst(rst), .frame_start(frame_start),
      .vnu_update_pend(pend), .layer_finish(lf), .syndrome_ok(synd),
      .v2c_mem_fetch(fetch), .cnu_rd(cnu), .c2v_bs_en(bs),
      .c2v_pa_en(pa), .c2v_mem_we(we), .layer_idx(layer),
      .iter_idx(iter), .last_layer(last), .busy(busy),
      .frame_done(fdone), .decode_fail(dfail), .state(st)
   );

   layered_cnu_sched_ctrl #(.CNU_PIPELINE_LEVEL(C6)) dut6 (
      .read_clk(clk), .rst(rst), .frame_start(frame_start),
      .vnu_update_pend(pend), .layer_finish(lf), .syndrome_ok(synd),
      .v2c_mem_fetch(fetch6), .cnu_rd(cnu6), .c2v_bs_en(bs6),
      .c2v_pa_en(pa6), .c2v_mem_we(we6), .layer_idx(layer6),
      .iter_idx(iter6), .last_layer(last6), .busy(busy6),
      .frame_done(fdone6), .decode_fail(dfail6), .state(st6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input logic [3:0] s, input string tag);
      int n = 0;
      while (st !== s && n < 64) begin
         step();
         n++;
      end
      chk(tag, st, s);
   endtask

   // Expected strobes {fetch,cnu,bs,pa,we} in cycle c after frame_start.
   function automatic logic [4:0] exp_str(input int c, input int cl);
      int f0, b0, p0, w0;
      f0 = 2 + B;
      b0 = f0 + M + cl;
      p0 = b0 + P;
      w0 = p0 + A;
      return {c == f0, (c >= f0 + M) && (c < b0), c == b0,
              (c >= p0) && (c < w0), c == w0};
   endfunction

   // Full frame against the iteration model; exp_k = layers expected.
   task automatic run_frame(input string tag, input bit rnd,
                            input int et_at, input int exp_k);
      int k, lat, exp_lat, d, h, itn;
      bit usep, sy, term, fail_exp;
      k = 0;
      h = 0;
      usep = 1'b1;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk({tag, "_start"}, {busy, dfail, layer, iter},
          {1'b1, 1'b0, 2'd0, 4'd0});
      while (k <= L * MI + 1) begin
         exp_lat = usep ? (h + 2 + B + M + C + P + A)
                        : (1 + M + C + P + A);
         lat = 1;
         while (we !== 1'b1 && lat < 200) begin
            pend = usep && (lat <= h);
            step();
            lat++;
         end
         pend = 1'b0;
         chk({tag, "_we_lat"}, lat, exp_lat);
         if (lat >= 200) return;
         chk({tag, "_we_idx"}, {layer, iter, last, dfail},
             {2'(k % L), 4'(k / L), (k % L) == L - 1, 1'b0});
         k++;
         d    = rnd ? int'($urandom_range(1, 4)) : 2;
         h    = rnd ? int'($urandom_range(0, 2)) : 0;
         usep = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         sy   = (k == et_at);
`ifndef EARLY_TERM_EN
         if (rnd) sy = 1'($urandom_range(0, 1));
`endif
         repeat (d) begin
            step();
            chk({tag, "_wait"}, {st, we}, {4'd8, 1'b0});
         end
         lf   = 1'b1;
         pend = usep;
         synd = sy;
         step();
         lf   = 1'b0;
         synd = 1'b0;
         itn  = k / L;
         term = 1'b0;
         fail_exp = 1'b0;
         if (k % L == 0) begin
`ifdef EARLY_TERM_EN
            if (sy) term = 1'b1;
`endif
            if (!term && itn == MI) begin
               term = 1'b1;
               fail_exp = 1'b1;
            end
         end
         if (term) begin
            pend = 1'b0;
            chk({tag, "_done"}, {st, fdone, dfail, iter, layer},
                {4'd9, 1'b1, fail_exp, 4'(itn), 2'd0});
            chk({tag, "_layers"}, k, exp_k);
            step();
            chk({tag, "_idle"}, {st, busy, fdone, dfail},
                {4'd0, 1'b0, 1'b0, fail_exp});
            return;
         end
      end
      chk({tag, "_runaway"}, k, exp_k);
   endtask

   initial begin
      rst = 1'b1;
      frame_start = 1'b0;
      pend = 1'b0;
      lf = 1'b0;
      synd = 1'b0;
      step();
      step();
      chk("rst_state", st, 4'd0);
      chk("rst_outs",
          {fetch, cnu, bs, pa, we, layer, iter, last, busy, fdone, dfail},
          15'd0);
      chk("rst_outs6", {st6, busy6, iter6, layer6, dfail6}, 12'd0);

      // Per-layer strobe timing, default and 6-deep CNU pipeline.
      rst = 1'b0;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         chk("timing4", {fetch, cnu, bs, pa, we}, exp_str(c, C));
         chk("timing6", {fetch6, cnu6, bs6, pa6, we6}, exp_str(c, C6));
         step();
      end

      // VNU update pending holds the schedule before the bubble.
      rst = 1'b1;
      step();
      rst = 1'b0;
      pend = 1'b1;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("pend_hold", {st, fetch, cnu, bs, pa, we}, {4'd1, 5'd0});
         if (i == 4) pend = 1'b0;
         step();
      end
      chk("bubble1", st, 4'd2);
      step();
      chk("bubble2", st, 4'd2);
      step();
      chk("fetch_in", {st, fetch}, {4'd3, 1'b1});

      // Stray layer_finish and frame_start are ignored.
      lf = 1'b1;
      step();
      lf = 1'b0;
      chk("lf_ignored", {st, layer, iter}, {4'd3, 2'd0, 4'd0});
      wait_state(4'd5, "to_bs");
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("fs_ignored", {st, layer, iter, bs}, {4'd5, 2'd0, 4'd0, 1'b0});
      wait_state(4'd8, "to_wait");
      repeat (3) step();
      chk("wait_hold", {st, layer, iter}, {4'd8, 2'd0, 4'd0});

      // Reset in the CNU pipeline drops the frame.
      rst = 1'b1;
      step();
      rst = 1'b0;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      wait_state(4'd4, "to_cnu");
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst",
          {st, fetch, cnu, bs, pa, we, layer, iter, last, busy,
           fdone, dfail}, 19'd0);
      chk("mid_rst6", {st6, cnu6, busy6}, 6'd0);

      run_frame("max", 1'b0, 0, L * MI);
      repeat (3) step();
      run_frame("rnd", 1'b1, 0, L * MI);
`ifdef EARLY_TERM_EN
      repeat (2) step();
      run_frame("et", 1'b0, 3, 3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
